// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared mode and state encodings for decoder_seq
package decoder_pkg;

   // Operating mode selected by the mode input
   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_SCAN   = 2'b01,
      MODE_SWEEP  = 2'b10,
      MODE_OFF    = 2'b11
   } mode_t;

   // Sequencer states; direct and off modes both live in ST_IDLE
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SCAN  = 2'b01,
      ST_SWEEP = 2'b10
   } state_t;

endpackage

// File: rtl/decoder_seq_if.sv
// rtl/decoder_seq_if.sv - control and decode bundle between a driver and decoder_seq
interface decoder_seq_if
   import decoder_pkg::*;
#(
   parameter int N = 3
) ();

   logic              en;
   mode_t             mode;
   logic [N-1:0]      a;
   logic              start;
   logic [(1<<N)-1:0] b;
   logic [N-1:0]      idx;
   logic              busy;
   logic              done;
   logic              wrap;

   modport master (
      output en, mode, a, start,
      input  b, idx, busy, done, wrap
   );

   modport slave (
      input  en, mode, a, start,
      output b, idx, busy, done, wrap
   );

endinterface

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - per-position hold counter for the scan and sweep modes
module dwell_timer #(
   parameter int DWELL = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(DWELL + 1);

   logic [CW-1:0] cnt_q;

   // Expiry marks the last enabled cycle of the current position
   assign expire = (cnt_q == CW'(DWELL - 1));

   // Count enabled cycles, wrapping to zero on expiry; load restarts a position
   always_ff @(posedge clk) begin
      if (rst || load) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= expire ? '0 : cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/decoder_seq.sv
// rtl/decoder_seq.sv - registered one-hot decoder with direct, scan and sweep modes
module decoder_seq
   import decoder_pkg::*;
#(
   parameter int N     = 3,
   parameter int DWELL = 1
) (
   input logic        clk,
   input logic        rst,
   decoder_seq_if.slave bus
);

   localparam int W = 1 << N;

   state_t         state_q, state_d;
   logic [N-1:0]   idx_q, idx_d;
   logic [W-1:0]   b_q, b_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           wrap_q, wrap_d;
   logic           drive;
   logic           tmr_load, tmr_en, tmr_expire;
   logic           at_last;

   dwell_timer #(.DWELL(DWELL)) u_dwell (
      .clk    (clk),
      .rst    (rst),
      .load   (tmr_load),
      .en     (tmr_en),
      .expire (tmr_expire)
   );

   assign at_last = (idx_q == {N{1'b1}});

   // Next-state, next-index and pulse decisions; b is only derived from idx_d
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      wrap_d   = 1'b0;
      drive    = 1'b0;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      if (bus.en) begin
         case (state_q)
            ST_IDLE: begin
               case (bus.mode)
                  MODE_DIRECT: begin
                     idx_d = bus.a;
                     drive = 1'b1;
                  end
                  MODE_SCAN: begin
                     state_d  = ST_SCAN;
                     idx_d    = '0;
                     drive    = 1'b1;
                     tmr_load = 1'b1;
                  end
                  MODE_SWEEP: begin
                     if (bus.start) begin
                        state_d  = ST_SWEEP;
                        idx_d    = '0;
                        busy_d   = 1'b1;
                        drive    = 1'b1;
                        tmr_load = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            ST_SCAN: begin
               if (bus.mode != MODE_SCAN) begin
                  state_d = ST_IDLE;
               end else begin
                  tmr_en = 1'b1;
                  drive  = 1'b1;
                  if (tmr_expire) begin
                     idx_d  = idx_q + N'(1);
                     wrap_d = at_last;
                  end
               end
            end
            ST_SWEEP: begin
               if (bus.mode != MODE_SWEEP) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  tmr_en = 1'b1;
                  if (tmr_expire && at_last) begin
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     idx_d   = '0;
                  end else begin
                     drive = 1'b1;
                     if (tmr_expire) begin
                        idx_d = idx_q + N'(1);
                     end
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign b_d = drive ? (W'(1) << idx_d) : '0;

   // State and output registers; reset wins over every other input
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.b    = b_q;
   assign bus.idx  = idx_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_seq.sv
// tb/tb_decoder_seq.sv - self-checking bench for decoder_seq
module tb_decoder_seq;
   import decoder_pkg::*;

   logic       clk;
   logic       rst;
   logic       en;
   logic       start;
   logic [1:0] mode;
   logic [2:0] a;

   int pass_cnt = 0;
   int total_cnt = 0;
   bit use_model = 0;

   decoder_seq_if #(.N(3)) bus1 ();
   decoder_seq_if #(.N(3)) bus2 ();

   assign bus1.en    = en;
   assign bus1.mode  = mode_t'(mode);
   assign bus1.a     = a;
   assign bus1.start = start;
   assign bus2.en    = en;
   assign bus2.mode  = mode_t'(mode);
   assign bus2.a     = a;
   assign bus2.start = start;

   decoder_seq #(.N(3), .DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   decoder_seq #(.N(3), .DWELL(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: elapsed enabled cycles since entry give the position
   int       m_kind [2];
   int       m_t    [2];
   int       m_idx  [2];
   logic [7:0] m_b  [2];
   logic     m_busy [2];
   logic     m_done [2];
   logic     m_wrap [2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step_model(input int k, input int d);
      m_done[k] = 1'b0;
      m_wrap[k] = 1'b0;
      if (rst) begin
         m_kind[k] = 0; m_t[k] = 0; m_idx[k] = 0; m_b[k] = '0; m_busy[k] = 1'b0;
      end else if (!en) begin
         m_b[k] = '0;
      end else if (m_kind[k] == 0) begin
         m_b[k] = '0;
         if (mode == 2'd0) begin
            m_idx[k] = int'(a);
            m_b[k] = 8'd1 << a;
         end else if (mode == 2'd1) begin
            m_kind[k] = 1; m_t[k] = 0; m_idx[k] = 0; m_b[k] = 8'd1;
         end else if (mode == 2'd2 && start) begin
            m_kind[k] = 2; m_t[k] = 0; m_idx[k] = 0; m_b[k] = 8'd1; m_busy[k] = 1'b1;
         end
      end else if (m_kind[k] == 1) begin
         if (mode != 2'd1) begin
            m_kind[k] = 0; m_b[k] = '0;
         end else begin
            m_t[k]++;
            m_idx[k] = (m_t[k] / d) % 8;
            m_wrap[k] = (m_t[k] % (8 * d)) == 0;
            m_b[k] = 8'd1 << m_idx[k];
         end
      end else begin
         if (mode != 2'd2) begin
            m_kind[k] = 0; m_busy[k] = 1'b0; m_b[k] = '0;
         end else begin
            m_t[k]++;
            if (m_t[k] == 8 * d) begin
               m_kind[k] = 0; m_done[k] = 1'b1; m_busy[k] = 1'b0; m_idx[k] = 0; m_b[k] = '0;
            end else begin
               m_idx[k] = m_t[k] / d;
               m_b[k] = 8'd1 << m_idx[k];
            end
         end
      end
   endtask

   task automatic compare_model();
      chk("d1_b",    bus1.b,    m_b[0]);
      chk("d1_idx",  bus1.idx,  m_idx[0]);
      chk("d1_busy", bus1.busy, m_busy[0]);
      chk("d1_done", bus1.done, m_done[0]);
      chk("d1_wrap", bus1.wrap, m_wrap[0]);
      chk("d1_onehot", (bus1.b == 8'd0) || (bus1.b == (8'd1 << bus1.idx)), 1);
      chk("d2_b",    bus2.b,    m_b[1]);
      chk("d2_idx",  bus2.idx,  m_idx[1]);
      chk("d2_busy", bus2.busy, m_busy[1]);
      chk("d2_done", bus2.done, m_done[1]);
      chk("d2_wrap", bus2.wrap, m_wrap[1]);
      chk("d2_onehot", (bus2.b == 8'd0) || (bus2.b == (8'd1 << bus2.idx)), 1);
   endtask

   task automatic cycle();
      @(posedge clk);
      step_model(0, 1);
      step_model(1, 2);
      #1;
      if (use_model) compare_model();
   endtask

   typedef struct {
      logic       en;
      logic [1:0] mode;
      logic [2:0] a;
      logic       start;
      logic [7:0] exp_b;
      int         exp_idx;
   } vec_t;

   vec_t vecs [11];

   initial begin
      int n;
      int wraps;
      int dones;
      for (int i = 0; i < 8; i++) vecs[i] = '{1'b1, 2'd0, 3'(i), 1'b0, 8'd1 << i, i};
      vecs[8]  = '{1'b0, 2'd0, 3'd5, 1'b0, 8'd0, 7};
      vecs[9]  = '{1'b1, 2'd3, 3'd2, 1'b0, 8'd0, 7};
      vecs[10] = '{1'b1, 2'd0, 3'd3, 1'b0, 8'd8, 3};

      rst = 1'b1; en = 1'b1; mode = 2'd2; start = 1'b1; a = 3'd6;
      cycle();
      chk("rst_b",    bus1.b, 0);
      chk("rst_idx",  bus1.idx, 0);
      chk("rst_busy", bus1.busy, 0);
      chk("rst_done", bus1.done, 0);
      chk("rst_wrap", bus2.wrap, 0);
      rst = 1'b0; start = 1'b0;

      // direct decode table
      for (int i = 0; i < 11; i++) begin
         en = vecs[i].en; mode = vecs[i].mode; a = vecs[i].a; start = vecs[i].start;
         cycle();
         chk($sformatf("tbl_b[%0d]", i), bus1.b, vecs[i].exp_b);
         chk($sformatf("tbl_idx[%0d]", i), bus1.idx, vecs[i].exp_idx);
      end

      // continuous scan, DWELL=2
      mode = 2'd3; cycle();
      mode = 2'd1; en = 1'b1; wraps = 0;
      for (int c = 1; c <= 20; c++) begin
         cycle();
         chk($sformatf("scan_idx[%0d]", c), bus2.idx, ((c - 1) / 2) % 8);
         chk($sformatf("scan_b[%0d]", c), bus2.b, 8'd1 << (((c - 1) / 2) % 8));
         chk($sformatf("scan_wrap[%0d]", c), bus2.wrap, c == 17);
         if (bus2.wrap) wraps++;
      end
      chk("scan_wrap_count", wraps, 1);

      // single sweep, DWELL=1
      mode = 2'd3; cycle();
      mode = 2'd2;
      for (int c = 1; c <= 9; c++) begin
         start = (c == 1);
         cycle();
         if (c <= 8) begin
            chk($sformatf("sw_busy[%0d]", c), bus1.busy, 1);
            chk($sformatf("sw_b[%0d]", c), bus1.b, 8'd1 << (c - 1));
            chk($sformatf("sw_done[%0d]", c), bus1.done, 0);
         end else begin
            chk("sw_done_end", bus1.done, 1);
            chk("sw_b_end", bus1.b, 0);
            chk("sw_busy_end", bus1.busy, 0);
            chk("sw_idx_end", bus1.idx, 0);
         end
      end
      cycle();
      chk("sw_done_pulse", bus1.done, 0);

      // sweep with an en=0 gap at idx 4
      mode = 2'd3; cycle();
      mode = 2'd2; start = 1'b1; cycle(); start = 1'b0;
      for (int c = 0; c < 4; c++) cycle();
      chk("gap_idx_before", bus1.idx, 4);
      en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         chk("gap_b", bus1.b, 0);
         chk("gap_idx", bus1.idx, 4);
         chk("gap_busy", bus1.busy, 1);
      end
      en = 1'b1; n = 0;
      while (n < 20) begin
         cycle();
         n++;
         if (bus1.done) break;
      end
      chk("gap_total_cycles", 7 + n, 11);

      // reset mid-sweep and ignored restart
      mode = 2'd3; cycle();
      mode = 2'd2; start = 1'b1; cycle(); start = 1'b0;
      cycle();
      start = 1'b1; cycle(); start = 1'b0;
      chk("restart_idx", bus1.idx, 2);
      chk("restart_busy", bus1.busy, 1);
      for (int c = 0; c < 3; c++) cycle();
      chk("pre_rst_idx", bus1.idx, 5);
      rst = 1'b1; cycle(); rst = 1'b0;
      chk("mid_rst_b", bus1.b, 0);
      chk("mid_rst_idx", bus1.idx, 0);
      chk("mid_rst_busy", bus1.busy, 0);
      chk("mid_rst_done", bus1.done, 0);
      dones = 0;
      for (int c = 0; c < 10; c++) begin
         cycle();
         if (bus1.done) dones++;
      end
      chk("post_rst_no_done", dones, 0);

      // randomized run against the reference model
      use_model = 1;
      for (int i = 0; i < 10000; i++) begin
         rst   = ($urandom_range(0, 199) == 0);
         en    = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         a     = 3'($urandom_range(0, 7));
         start = ($urandom_range(0, 7) == 0);
         cycle();
      end
      use_model = 0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
